// File: rtl/alu_operand_sequencer_if.sv
// ---------------------------------------------------------------------------
// alu_operand_sequencer_if
//   Instruction handshake bundle between an instruction source and the
//   ALU operand sequencer.
//
//   instr_valid  source -> sequencer  instruction offered
//   instr_ready  sequencer -> source  sequencer can accept an instruction
//   instr_sel    source -> sequencer  ALU operation code
//   instr_rd     source -> sequencer  destination register
//   instr_rs1    source -> sequencer  source register for ALU a
//   instr_rs2    source -> sequencer  source register for ALU b
//
//   master : the instruction source
//   slave  : the sequencer
// ---------------------------------------------------------------------------
interface alu_operand_sequencer_if #(
   parameter int AW = 3
);
   logic          instr_valid;
   logic          instr_ready;
   logic [3:0]    instr_sel;
   logic [AW-1:0] instr_rd;
   logic [AW-1:0] instr_rs1;
   logic [AW-1:0] instr_rs2;

   modport master (
      output instr_valid,
      input  instr_ready,
      output instr_sel,
      output instr_rd,
      output instr_rs1,
      output instr_rs2
   );

   modport slave (
      input  instr_valid,
      output instr_ready,
      input  instr_sel,
      input  instr_rd,
      input  instr_rs1,
      input  instr_rs2
   );
endinterface

// File: rtl/alu_operand_sequencer.sv
// ---------------------------------------------------------------------------
// alu_operand_sequencer
//   Control stage in front of a combinational DW-bit ALU. Holds an NREG-entry
//   register file, accepts one instruction at a time, presents registered
//   operands/select to the ALU, writes the ALU result back and reports it on
//   a one-cycle strobe together with a zero flag. A side load port writes
//   the register file in any state.
//
//   Ports:
//     clk, rst_n          clock, asynchronous active-low reset
//     bus (slave)         instruction handshake (valid/ready, sel, rd, rs1, rs2)
//     ld_en/addr/data     register file load port
//     alu_a/alu_b/alu_sel registered ALU inputs, change once per instruction
//     alu_out             combinational ALU result
//     res_valid           one-cycle strobe: result written back
//     res_data/rd/zero    captured result, destination and zero flag (held)
//     busy                high while an instruction is in READ or EXEC
//
//   Timing: accept at edge N, operands registered at N+1, writeback at N+2,
//   res_valid high in the cycle after N+2, which is also the first cycle
//   instr_ready is high again.
// ---------------------------------------------------------------------------
module alu_operand_sequencer #(
   parameter int DW   = 16,
   parameter int NREG = 8,
   localparam int AW  = $clog2(NREG)
) (
   input  logic                   clk,
   input  logic                   rst_n,
   alu_operand_sequencer_if.slave bus,
   input  logic                   ld_en,
   input  logic [AW-1:0]          ld_addr,
   input  logic [DW-1:0]          ld_data,
   output logic [DW-1:0]          alu_a,
   output logic [DW-1:0]          alu_b,
   output logic [3:0]             alu_sel,
   input  logic [DW-1:0]          alu_out,
   output logic                   res_valid,
   output logic [DW-1:0]          res_data,
   output logic [AW-1:0]          res_rd,
   output logic                   res_zero,
   output logic                   busy
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_READ = 2'd1,
      ST_EXEC = 2'd2
   } state_t;

   state_t        state_r;
   logic [3:0]    sel_r;
   logic [AW-1:0] rd_r;
   logic [AW-1:0] rs1_r;
   logic [AW-1:0] rs2_r;
   logic          ready_r;
   logic [DW-1:0] rf_r [NREG];
   logic          accept_s;

   function automatic logic is_zero(input logic [DW-1:0] v);
      is_zero = (v == {DW{1'b0}});
   endfunction

   assign bus.instr_ready = ready_r;

   // Handshake qualifier; ready_r is only high in IDLE.
   always_comb begin
      accept_s = 1'b0;
      if (bus.instr_valid && ready_r) begin
         accept_s = 1'b1;
      end else begin
         accept_s = 1'b0;
      end
   end

   // Sequencer FSM, register file and all registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r   <= ST_IDLE;
         sel_r     <= 4'd0;
         rd_r      <= {AW{1'b0}};
         rs1_r     <= {AW{1'b0}};
         rs2_r     <= {AW{1'b0}};
         ready_r   <= 1'b1;
         busy      <= 1'b0;
         alu_a     <= {DW{1'b0}};
         alu_b     <= {DW{1'b0}};
         alu_sel   <= 4'd0;
         res_valid <= 1'b0;
         res_data  <= {DW{1'b0}};
         res_rd    <= {AW{1'b0}};
         res_zero  <= 1'b1;
         for (int i = 0; i < NREG; i++) begin
            rf_r[i] <= {DW{1'b0}};
         end
      end else begin
         res_valid <= 1'b0;

         // Side load first: a writeback to the same entry later in this
         // block overrides it, so the writeback wins a same-edge collision.
         if (ld_en) begin
            rf_r[ld_addr] <= ld_data;
         end

         case (state_r)
            ST_IDLE: begin
               if (accept_s) begin
                  sel_r   <= bus.instr_sel;
                  rd_r    <= bus.instr_rd;
                  rs1_r   <= bus.instr_rs1;
                  rs2_r   <= bus.instr_rs2;
                  ready_r <= 1'b0;
                  busy    <= 1'b1;
                  state_r <= ST_READ;
               end else begin
                  ready_r <= 1'b1;
                  busy    <= 1'b0;
                  state_r <= ST_IDLE;
               end
            end
            ST_READ: begin
               // rf_r still holds pre-edge values, so a same-edge load to a
               // source register does not affect the operand.
               alu_a   <= rf_r[rs1_r];
               alu_b   <= rf_r[rs2_r];
               alu_sel <= sel_r;
               ready_r <= 1'b0;
               busy    <= 1'b1;
               state_r <= ST_EXEC;
            end
            ST_EXEC: begin
               rf_r[rd_r] <= alu_out;
               res_data   <= alu_out;
               res_rd     <= rd_r;
               res_zero   <= is_zero(alu_out);
               res_valid  <= 1'b1;
               ready_r    <= 1'b1;
               busy       <= 1'b0;
               state_r    <= ST_IDLE;
            end
            default: begin
               ready_r <= 1'b1;
               busy    <= 1'b0;
               state_r <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_operand_sequencer.sv
// ---------------------------------------------------------------------------
// tb_alu_operand_sequencer
//   Self-checking bench: a transaction-level model (register array plus an
//   "edges since accept" counter) predicts every output each cycle; directed
//   scenarios add literal expectations, followed by randomized traffic.
// ---------------------------------------------------------------------------
module tb_alu_operand_sequencer;

   logic        clk;
   logic        rst_n;
   logic        ld_en;
   logic [2:0]  ld_addr;
   logic [15:0] ld_data;
   logic [15:0] alu_a, alu_b, alu_out;
   logic [3:0]  alu_sel;
   logic        res_valid, res_zero, busy;
   logic [15:0] res_data;
   logic [2:0]  res_rd;

   alu_operand_sequencer_if #(.AW(3)) bus ();

   alu_operand_sequencer #(.DW(16), .NREG(8)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .bus      (bus),
      .ld_en    (ld_en),
      .ld_addr  (ld_addr),
      .ld_data  (ld_data),
      .alu_a    (alu_a),
      .alu_b    (alu_b),
      .alu_sel  (alu_sel),
      .alu_out  (alu_out),
      .res_valid(res_valid),
      .res_data (res_data),
      .res_rd   (res_rd),
      .res_zero (res_zero),
      .busy     (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Stand-in combinational ALU; undefined codes return 0.
   function automatic logic [15:0] alu_f(input logic [15:0] a, input logic [15:0] b,
                                         input logic [3:0] s);
      case (s)
         4'd0:    alu_f = a + b;
         4'd1:    alu_f = a - b;
         4'd2:    alu_f = a & b;
         4'd3:    alu_f = a | b;
         4'd6:    alu_f = a ^ b;
         4'd7:    alu_f = b;
         default: alu_f = 16'h0000;
      endcase
   endfunction

   assign alu_out = alu_f(alu_a, alu_b, alu_sel);

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   int last_pulse = 0;
   int pulse_gap = 0;

   // Model state
   logic [15:0] m_rf [8];
   int          since;      // -1: idle, else edges since accept
   logic [3:0]  l_sel;
   logic [2:0]  l_rd, l_rs1, l_rs2;
   logic [15:0] e_a, e_b, e_data;
   logic [3:0]  e_sel;
   logic [2:0]  e_rd;
   logic        e_rv, e_zero, m_acc;

   task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 8; i++) m_rf[i] = 16'h0000;
      since  = -1;
      e_a    = 16'h0000;
      e_b    = 16'h0000;
      e_sel  = 4'd0;
      e_data = 16'h0000;
      e_rd   = 3'd0;
      e_rv   = 1'b0;
      e_zero = 1'b1;
      m_acc  = 1'b0;
   endtask

   // Effect of one rising edge, from the inputs applied before it.
   task automatic model_edge();
      logic [15:0] r;
      logic        was_busy;
      m_acc = 1'b0;
      if (!rst_n) begin
         model_reset();
         return;
      end
      was_busy = (since >= 0);
      e_rv = 1'b0;
      r = 16'h0000;
      if (since == 1) r = alu_f(e_a, e_b, e_sel);
      if (since == 0) begin
         e_a   = m_rf[l_rs1];
         e_b   = m_rf[l_rs2];
         e_sel = l_sel;
      end
      if (ld_en) m_rf[ld_addr] = ld_data;
      if (since == 1) begin
         m_rf[l_rd] = r;
         e_data = r;
         e_rd   = l_rd;
         e_zero = (r == 16'h0000);
         e_rv   = 1'b1;
         since  = -1;
      end else if (since == 0) begin
         since = 1;
      end
      if (bus.instr_valid && !was_busy) begin
         l_sel = bus.instr_sel;
         l_rd  = bus.instr_rd;
         l_rs1 = bus.instr_rs1;
         l_rs2 = bus.instr_rs2;
         since = 0;
         m_acc = 1'b1;
      end
   endtask

   task automatic compare();
      chk("instr_ready", {15'd0, bus.instr_ready}, {15'd0, since < 0});
      chk("busy",        {15'd0, busy},            {15'd0, since >= 0});
      chk("alu_a",       alu_a,                    e_a);
      chk("alu_b",       alu_b,                    e_b);
      chk("alu_sel",     {12'd0, alu_sel},         {12'd0, e_sel});
      chk("res_valid",   {15'd0, res_valid},       {15'd0, e_rv});
      chk("res_data",    res_data,                 e_data);
      chk("res_rd",      {13'd0, res_rd},          {13'd0, e_rd});
      chk("res_zero",    {15'd0, res_zero},        {15'd0, e_zero});
   endtask

   task automatic tick();
      @(posedge clk);
      cyc++;
      model_edge();
      #1;
      compare();
      if (res_valid === 1'b1) begin
         pulse_gap  = cyc - last_pulse;
         last_pulse = cyc;
      end
   endtask

   task automatic load(input logic [2:0] a, input logic [15:0] d);
      ld_en = 1'b1; ld_addr = a; ld_data = d;
      tick();
      ld_en = 1'b0;
   endtask

   // Offer an instruction and hold it until accepted (bounded).
   task automatic issue(input logic [3:0] s, input logic [2:0] rd,
                        input logic [2:0] rs1, input logic [2:0] rs2);
      bit got;
      got = 1'b0;
      bus.instr_valid = 1'b1;
      bus.instr_sel = s; bus.instr_rd = rd; bus.instr_rs1 = rs1; bus.instr_rs2 = rs2;
      for (int k = 0; k < 10 && !got; k++) begin
         tick();
         got = m_acc;
      end
      if (!got) chk("accept_timeout", 16'd0, 16'd1);
      bus.instr_valid = 1'b0;
   endtask

   // Read a register back through an OR of it with itself.
   task automatic read_reg(input string nm, input logic [2:0] r, input logic [15:0] exp);
      issue(4'd3, r, r, r);
      tick();
      tick();
      chk({nm, "_valid"}, {15'd0, res_valid}, 16'd1);
      chk(nm, res_data, exp);
   endtask

   initial begin
      rst_n = 1'b0;
      ld_en = 1'b0; ld_addr = 3'd0; ld_data = 16'h0000;
      bus.instr_valid = 1'b0; bus.instr_sel = 4'd0;
      bus.instr_rd = 3'd0; bus.instr_rs1 = 3'd0; bus.instr_rs2 = 3'd0;
      l_sel = 4'd0; l_rd = 3'd0; l_rs1 = 3'd0; l_rs2 = 3'd0;
      model_reset();
      tick(); tick();
      rst_n = 1'b1;
      tick();

      // Add: r3 = r1 + r2
      load(3'd1, 16'h0003);
      load(3'd2, 16'h0005);
      issue(4'd0, 3'd3, 3'd1, 3'd2);
      tick();
      chk("add_early_valid", {15'd0, res_valid}, 16'd0);
      tick();
      chk("add_valid", {15'd0, res_valid}, 16'd1);
      chk("add_data", res_data, 16'h0008);
      chk("add_rd", {13'd0, res_rd}, 16'd3);
      chk("add_zero", {15'd0, res_zero}, 16'd0);
      read_reg("rf3", 3'd3, 16'h0008);

      // Sub to zero, then wrap
      issue(4'd1, 3'd3, 3'd1, 3'd1);
      tick(); tick();
      chk("sub_zero_data", res_data, 16'h0000);
      chk("sub_zero_flag", {15'd0, res_zero}, 16'd1);
      load(3'd0, 16'h0000);
      load(3'd1, 16'h0001);
      issue(4'd1, 3'd3, 3'd0, 3'd1);
      tick(); tick();
      chk("sub_wrap", res_data, 16'hFFFF);

      // Back-to-back dependency
      load(3'd1, 16'h0003);
      issue(4'd0, 3'd4, 3'd1, 3'd2);
      tick(); tick();
      chk("b2b_first", res_data, 16'h0008);
      issue(4'd6, 3'd5, 3'd4, 3'd2);
      tick(); tick();
      chk("b2b_second", res_data, 16'h000D);
      chk("b2b_gap", pulse_gap[15:0], 16'd3);

      // Load/writeback collision on r6, instr_valid held while busy
      issue(4'd0, 3'd6, 3'd1, 3'd2);
      bus.instr_valid = 1'b1;
      bus.instr_sel = 4'd7; bus.instr_rd = 3'd1; bus.instr_rs1 = 3'd0; bus.instr_rs2 = 3'd0;
      tick();
      ld_en = 1'b1; ld_addr = 3'd6; ld_data = 16'h1234;
      tick();
      ld_en = 1'b0;
      bus.instr_valid = 1'b0;
      chk("coll_ready_during_busy", {15'd0, res_valid}, 16'd1);
      tick(); tick(); tick();
      chk("no_spurious_accept", {15'd0, busy}, 16'd0);
      read_reg("rf6", 3'd6, 16'h0008);
      read_reg("rf1_kept", 3'd1, 16'h0003);

      // Reset during READ
      load(3'd7, 16'h00AA);
      issue(4'd0, 3'd7, 3'd1, 3'd2);
      rst_n = 1'b0;
      #1;
      model_reset();
      compare();
      chk("rst_ready", {15'd0, bus.instr_ready}, 16'd1);
      tick(); tick();
      rst_n = 1'b1;
      tick(); tick(); tick();
      read_reg("rf7_after_rst", 3'd7, 16'h0000);
      read_reg("rf1_after_rst", 3'd1, 16'h0000);

      // Randomized traffic
      for (int n = 0; n < 600; n++) begin
         if (!bus.instr_valid && $urandom_range(0, 1) == 0) begin
            bus.instr_valid = 1'b1;
            bus.instr_sel = 4'($urandom_range(0, 15));
            bus.instr_rd  = 3'($urandom_range(0, 7));
            bus.instr_rs1 = 3'($urandom_range(0, 7));
            bus.instr_rs2 = 3'($urandom_range(0, 7));
         end
         ld_en   = ($urandom_range(0, 3) == 0);
         ld_addr = 3'($urandom_range(0, 7));
         ld_data = 16'($urandom_range(0, 65535));
         if ($urandom_range(0, 7) == 0) ld_data = 16'h0000;
         tick();
         if (m_acc) bus.instr_valid = 1'b0;
      end
      ld_en = 1'b0;
      bus.instr_valid = 1'b0;
      tick(); tick(); tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
